// File: rtl/pixel_pkg.sv
// pixel_pkg: shared pixel-processing modes and fixed-point gain constants
package pixel_pkg;
  typedef enum logic [1:0] {BYPASS, SCALE, INVERT, INVERT_SCALE} mode_e;
  localparam int FRAC_W = 8;
  localparam int UNITY_GAIN = 1 << FRAC_W;
endpackage

// File: rtl/pixel_channel_scale.sv
// pixel_channel_scale: one channel's invert/multiply (S1) and round/saturate (S2) datapath
module pixel_channel_scale
  import pixel_pkg::*;
#(
  parameter int CH_W = 8,
  parameter int GAIN_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld1,
  input  logic              ld2,
  input  logic [CH_W-1:0]   x,
  input  logic [GAIN_W-1:0] gain,
  input  mode_e             mode,
  output logic [CH_W-1:0]   y,
  output logic              clip
);
  localparam int P_W = CH_W + GAIN_W;
  localparam int R_W = P_W + 1;
  localparam logic [CH_W-1:0] MAX_V = '1;
  logic [P_W-1:0] p1;
  logic [CH_W-1:0] xi;
  logic [GAIN_W-1:0] ge;
  logic [R_W-1:0] r;
  // Non-scaling modes multiply by unity so one datapath serves all four modes
  always_comb begin
    xi = (mode == INVERT || mode == INVERT_SCALE) ? ~x : x;
    ge = (mode == SCALE || mode == INVERT_SCALE) ? gain : GAIN_W'(UNITY_GAIN);
    r = (R_W'(p1) + R_W'(1 << (FRAC_W - 1))) >> FRAC_W;
    clip = r > R_W'(MAX_V);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      p1 <= '0;
      y <= '0;
    end else begin
      if (ld1) p1 <= P_W'(xi) * P_W'(ge);
      if (ld2) y <= clip ? MAX_V : r[CH_W-1:0];
    end
  end
endmodule

// File: rtl/pixel_gain_pipeline.sv
// pixel_gain_pipeline: two-stage elastic Avalon-ST per-channel gain/invert pipeline
module pixel_gain_pipeline
  import pixel_pkg::*;
#(
  parameter int CH_W = 8,
  parameter int PAD_W = 2,
  parameter int NUM_CH = 3,
  parameter int GAIN_W = 9,
  localparam int DATA_W = NUM_CH * (CH_W + PAD_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [GAIN_W-1:0] gain,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] data_in,
  input  logic              startofpacket_in,
  input  logic              endofpacket_in,
  input  logic              valid_in,
  output logic              ready_in,
  output logic [DATA_W-1:0] data_out,
  output logic              startofpacket_out,
  output logic              endofpacket_out,
  output logic              valid_out,
  input  logic              ready_out,
  output logic              clip_seen
);
  localparam int SLOT = CH_W + PAD_W;
  logic s1_v, s1_sop, s1_eop, s1_id, pkt_id;
  logic s1_ld, s2_ld, sop_acc;
  logic [GAIN_W-1:0] act_gain, gain_eff;
  mode_e act_mode, mode_eff;
  logic [NUM_CH-1:0] clip;
  assign s2_ld = s1_v && (!valid_out || ready_out);
  assign ready_in = !s1_v || s2_ld;
  assign s1_ld = valid_in && ready_in;
  assign sop_acc = s1_ld && startofpacket_in;
  // The SOP beat itself already uses the freshly requested gain and mode
  assign gain_eff = sop_acc ? gain : act_gain;
  assign mode_eff = sop_acc ? mode_e'(mode) : act_mode;
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [CH_W-1:0] y;
    logic unused_pad;
    assign unused_pad = ^data_in[DATA_W-1-k*SLOT-CH_W -: PAD_W];
    pixel_channel_scale #(.CH_W(CH_W), .GAIN_W(GAIN_W)) u_scale (
      .clk(clk),
      .reset(reset),
      .ld1(s1_ld),
      .ld2(s2_ld),
      .x(data_in[DATA_W-1-k*SLOT -: CH_W]),
      .gain(gain_eff),
      .mode(mode_eff),
      .y(y),
      .clip(clip[k])
    );
    assign data_out[DATA_W-1-k*SLOT -: SLOT] = SLOT'(y) << PAD_W;
  end
  // pkt_id toggles per accepted SOP so stale beats of the previous packet never set clip_seen
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_v <= 1'b0;
      s1_sop <= 1'b0;
      s1_eop <= 1'b0;
      s1_id <= 1'b0;
      pkt_id <= 1'b0;
      valid_out <= 1'b0;
      startofpacket_out <= 1'b0;
      endofpacket_out <= 1'b0;
      clip_seen <= 1'b0;
      act_gain <= GAIN_W'(UNITY_GAIN);
      act_mode <= BYPASS;
    end else begin
      if (s1_ld) begin
        s1_sop <= startofpacket_in;
        s1_eop <= endofpacket_in;
        s1_id <= pkt_id ^ startofpacket_in;
      end
      s1_v <= s1_ld || (s1_v && !s2_ld);
      if (s2_ld) begin
        startofpacket_out <= s1_sop;
        endofpacket_out <= s1_eop;
      end
      valid_out <= s2_ld || (valid_out && !ready_out);
      if (sop_acc) begin
        act_gain <= gain;
        act_mode <= mode_e'(mode);
        pkt_id <= !pkt_id;
      end
      clip_seen <= sop_acc ? 1'b0 : clip_seen || (s2_ld && |clip && s1_id == pkt_id);
    end
  end
endmodule

// File: tb/tb_pixel_gain_pipeline.sv
// tb_pixel_gain_pipeline: table-driven and sequence checks for pixel_gain_pipeline
module tb_pixel_gain_pipeline;
  logic clk = 0;
  logic reset;
  logic [8:0] gain;
  logic [1:0] mode;
  logic [29:0] data_in, data_out;
  logic sop_in, eop_in, valid_in, ready_in;
  logic sop_out, eop_out, valid_out, ready_out, clip_seen;
  int total = 0;
  int bad = 0;
  typedef struct {
    int a, b, c, g, m, ea, eb, ec;
    bit eclip;
  } vec_t;
  vec_t vt[9];
  logic [29:0] s_in[16], s_exp[16];
  logic [8:0] s_g[16];
  logic [1:0] s_m[16];
  bit s_sop[16], s_eop[16];

  pixel_gain_pipeline dut (
    .clk(clk), .reset(reset), .gain(gain), .mode(mode),
    .data_in(data_in), .startofpacket_in(sop_in), .endofpacket_in(eop_in),
    .valid_in(valid_in), .ready_in(ready_in),
    .data_out(data_out), .startofpacket_out(sop_out), .endofpacket_out(eop_out),
    .valid_out(valid_out), .ready_out(ready_out), .clip_seen(clip_seen)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] px(input int a, input int b, input int c, input logic [1:0] pad);
    return {8'(a), pad, 8'(b), pad, 8'(c), pad};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic run_stream(input int n, input int st0, input int stl);
    int idx = 0;
    int oidx = 0;
    int maxfl = 0;
    bit blocked = 0;
    bit prev_hold = 0;
    logic [29:0] prev = '0;
    for (int cyc = 0; cyc < 80 && oidx < n; cyc++) begin
      ready_out = !(cyc >= st0 && cyc < st0 + stl);
      valid_in = idx < n;
      if (idx < n) begin
        data_in = s_in[idx];
        gain = s_g[idx];
        mode = s_m[idx];
        sop_in = s_sop[idx];
        eop_in = s_eop[idx];
      end
      #1;
      if (prev_hold) begin
        chk("hold_valid", valid_out, 1);
        chk("hold_data", data_out, prev);
      end
      if (!ready_out && !ready_in) blocked = 1;
      if (valid_out && ready_out) begin
        chk($sformatf("stream_data[%0d]", oidx), data_out, s_exp[oidx]);
        chk($sformatf("stream_sop[%0d]", oidx), sop_out, s_sop[oidx]);
        chk($sformatf("stream_eop[%0d]", oidx), eop_out, s_eop[oidx]);
        oidx++;
      end
      if (valid_in && ready_in) idx++;
      if (idx - oidx > maxfl) maxfl = idx - oidx;
      prev_hold = valid_out && !ready_out;
      prev = data_out;
      @(posedge clk);
      #1;
    end
    valid_in = 0;
    ready_out = 1;
    chk("stream_count", oidx, n);
    step();
    chk("stream_no_extra", valid_out, 0);
    if (stl > 0) begin
      chk("stream_backpressure", blocked, 1);
      chk("stream_capacity", maxfl, 2);
    end
  endtask

  initial begin
    vt[0] = '{200, 100, 0, 128, 1, 100, 50, 0, 1'b0};
    vt[1] = '{200, 150, 1, 384, 1, 255, 225, 2, 1'b1};
    vt[2] = '{0, 255, 10, 384, 2, 255, 0, 245, 1'b0};
    vt[3] = '{12, 34, 56, 0, 0, 12, 34, 56, 1'b0};
    vt[4] = '{55, 255, 0, 128, 3, 100, 0, 128, 1'b0};
    vt[5] = '{255, 1, 0, 511, 1, 255, 2, 0, 1'b1};
    vt[6] = '{255, 128, 7, 256, 1, 255, 128, 7, 1'b0};
    vt[7] = '{255, 0, 1, 257, 1, 255, 0, 1, 1'b1};
    vt[8] = '{128, 127, 255, 1, 1, 1, 0, 1, 1'b0};
    reset = 0;
    ready_out = 1;
    valid_in = 0;
    sop_in = 0;
    eop_in = 0;
    gain = 0;
    mode = 0;
    data_in = '0;
    repeat (3) step();
    chk("rst_valid", valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_sop", sop_out, 0);
    chk("rst_eop", eop_out, 0);
    chk("rst_clip", clip_seen, 0);
    chk("rst_ready_in", ready_in, 1);
    reset = 1;
    step();
    foreach (vt[i]) begin
      gain = 9'(vt[i].g);
      mode = 2'(vt[i].m);
      data_in = px(vt[i].a, vt[i].b, vt[i].c, 2'b11);
      sop_in = 1;
      eop_in = 1;
      valid_in = 1;
      chk($sformatf("v%0d_ready_in", i), ready_in, 1);
      step();
      valid_in = 0;
      gain = 9'h1ff;
      mode = 2'd3;
      data_in = '1;
      chk($sformatf("v%0d_latency1", i), valid_out, 0);
      step();
      chk($sformatf("v%0d_valid", i), valid_out, 1);
      chk($sformatf("v%0d_data", i), data_out, px(vt[i].ea, vt[i].eb, vt[i].ec, 2'b00));
      chk($sformatf("v%0d_sop", i), sop_out, 1);
      chk($sformatf("v%0d_eop", i), eop_out, 1);
      chk($sformatf("v%0d_clip", i), clip_seen, vt[i].eclip);
    end
    step();
    for (int i = 0; i < 10; i++) begin
      s_in[i] = px(i * 20 + 3, i * 7, 250 - i, 2'b01);
      s_exp[i] = px(i * 20 + 3, i * 7, 250 - i, 2'b00);
      s_g[i] = 9'd256;
      s_m[i] = 2'd0;
      s_sop[i] = i == 0;
      s_eop[i] = i == 9;
    end
    run_stream(10, 3, 5);
    for (int i = 0; i < 8; i++) begin
      s_in[i] = px(200, 100, 40, 2'b10);
      s_exp[i] = i < 6 ? px(200, 100, 40, 2'b00) : px(50, 25, 10, 2'b00);
      s_g[i] = (i >= 4 && i <= 6) ? 9'd64 : 9'd256;
      s_m[i] = 2'd1;
      s_sop[i] = i == 0 || i == 6;
      s_eop[i] = i == 5 || i == 7;
    end
    run_stream(8, 100, 0);
    chk("gainchg_clip", clip_seen, 0);
    mode = 2'd1;
    gain = 9'd384;
    valid_in = 1;
    for (int b = 0; b < 3; b++) begin
      data_in = px(200, 200, 200, 2'b00);
      sop_in = b == 0;
      eop_in = 0;
      step();
    end
    chk("prerst_valid", valid_out, 1);
    chk("prerst_data", data_out, px(255, 255, 255, 2'b00));
    chk("prerst_clip", clip_seen, 1);
    sop_in = 0;
    reset = 0;
    step();
    chk("midrst_valid", valid_out, 0);
    chk("midrst_data", data_out, 0);
    chk("midrst_clip", clip_seen, 0);
    chk("midrst_sop", sop_out, 0);
    reset = 1;
    valid_in = 0;
    #1;
    chk("postrst_ready_in", ready_in, 1);
    step();
    gain = 9'd128;
    mode = 2'd1;
    data_in = px(90, 80, 70, 2'b00);
    valid_in = 1;
    step();
    valid_in = 0;
    step();
    chk("postrst_active_valid", valid_out, 1);
    chk("postrst_active_data", data_out, px(90, 80, 70, 2'b00));
    gain = 9'd256;
    data_in = px(11, 22, 33, 2'b11);
    sop_in = 1;
    eop_in = 1;
    valid_in = 1;
    step();
    valid_in = 0;
    step();
    chk("postrst_pkt_data", data_out, px(11, 22, 33, 2'b00));
    chk("postrst_pkt_sop", sop_out, 1);
    chk("postrst_pkt_clip", clip_seen, 0);
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pixel_gain_pipeline.md
PIXEL_GAIN_PIPELINE -- requirements
Module: pixel_gain_pipeline

Interface
REQ-001 SHALL have parameter CH_W, default 8, meaning bits per colour channel.
REQ-002 SHALL have parameter PAD_W, default 2, meaning zero-pad bits below each channel.
REQ-003 SHALL have parameter NUM_CH, default 3, meaning channel count; DATA_W = NUM_CH*(CH_W+PAD_W).
REQ-004 SHALL have parameter GAIN_W, default 9, meaning unsigned gain width, fixed-point with FRAC_W=8 fraction bits (256 = unity).
REQ-005 SHALL have port clk, in, 1, meaning sole clock; all logic rising-edge.
REQ-006 SHALL have port reset, in, 1, meaning synchronous active-low reset.
REQ-007 SHALL have port gain, in, GAIN_W, meaning requested channel gain.
REQ-008 SHALL have port mode, in, 2, meaning requested mode, as defined in REQ-015.
REQ-009 SHALL have sink ports data_in (DATA_W), startofpacket_in, endofpacket_in, valid_in (in) and ready_in (out), meaning Avalon-ST sink.
REQ-010 SHALL have source ports data_out (DATA_W), startofpacket_out, endofpacket_out, valid_out (out) and ready_out (in), meaning Avalon-ST source.
REQ-011 SHALL have port clip_seen, out, 1, meaning at least one channel saturated since the last accepted SOP.

Function
REQ-012 SHALL place channel 0 in the most-significant slot: channel k at bits [DATA_W-1-k*(CH_W+PAD_W) -: CH_W], with its PAD_W pad bits immediately below; pad bits ignored on input and driven 0 on output.
REQ-013 SHALL be a two-stage elastic pipeline: S1 multiply, S2 round/saturate/output register; latency exactly 2 cycles from input beat acceptance to valid_out with ready_out held high.
REQ-014 SHALL accept a beat when valid_in&&ready_in; each stage loads when it is empty or its contents advance that cycle; ready_in = !S1_valid || S1 advances (combinational, no dependence on valid_in); full throughput of 1 beat/cycle; 2-beat capacity when ready_out is low.
REQ-015 SHALL implement modes: 0 BYPASS (channel unchanged); 1 SCALE; 2 INVERT ((2^CH_W-1)-x, no scaling); 3 INVERT_SCALE (invert, then scale).
REQ-016 SHALL compute SCALE as y = (x*g + 2^(FRAC_W-1)) >> FRAC_W at CH_W+GAIN_W+1 bits, saturating to 2^CH_W-1 when the result exceeds it.
REQ-017 SHALL sample gain and mode into active registers only on the cycle a beat with startofpacket_in=1 is accepted; that SOP beat and all following beats use the new values; changes mid-packet have no effect until the next accepted SOP.
REQ-018 SHALL carry startofpacket and endofpacket through the pipeline alongside data, unmodified.
REQ-019 SHALL hold data_out, sop, eop and valid_out stable while valid_out=1 and ready_out=0.
REQ-020 SHALL clear clip_seen on an accepted SOP beat, then set it when a beat of the same packet saturates in S2; a saturating SOP beat leaves clip_seen=1; the flag stays sticky until the next accepted SOP.
REQ-021 SHALL NOT enforce packet framing; a missing EOP or a duplicate SOP is passed through, and each accepted SOP resamples gain and mode.

Reset
REQ-022 SHALL, while reset=0 at a clock edge, clear S1/S2 valid, drive valid_out=0, startofpacket_out=0, endofpacket_out=0, data_out=0 and clip_seen=0, and load active gain=256 and mode=BYPASS.
REQ-023 SHALL discard beats in flight when reset is asserted mid-packet; after release, ready_in=1 on the first cycle.

Structure
REQ-024 SHALL take the mode enum (BYPASS, SCALE, INVERT, INVERT_SCALE), FRAC_W and UNITY_GAIN from shared package pixel_pkg.
REQ-025 SHALL instantiate sub-module pixel_channel_scale NUM_CH times (generate loop); each instance holds one channel's invert, multiply, round and saturate logic and a clip output.

Verification
REQ-026 SHALL cover: SOP beat {200,100,0}, gain=128, mode=SCALE, ready_out=1 -> {100,50,0} two cycles later, clip_seen=0.
REQ-027 SHALL cover: gain=384 SCALE, pixel {200,150,1} -> {255,225,2}; clip_seen=1 from that beat until the next SOP.
REQ-028 SHALL cover: mode=INVERT, pixel {0,255,10} -> {255,0,245}; mode=BYPASS, gain=0 -> output equals input, pad bits 0.
REQ-029 SHALL cover: a 10-beat packet with ready_out low for 5 cycles mid-stream -> ready_in low after 2 beats are buffered, no beat lost or duplicated, order and eop preserved.
REQ-030 SHALL cover: gain changes 256->64 at beat 4 of a packet -> remaining beats unscaled; the next packet's SOP uses 64.
REQ-031 SHALL cover: reset=0 at beat 3 of a packet -> valid_out=0 the next cycle, active gain=256, and the first post-reset packet passes unscaled if its SOP is sampled with gain=256.
